// File: rtl/bcrypt_pkg.sv
// Shared definitions for the bcrypt output path: FSM encoding, field widths
// and per-proxy latency extraction from the packed latency vector.
package bcrypt_pkg;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      DRAIN,
      UNLOAD,
      GUARD
   } state_t;

   localparam int LAT_W       = 4;
   localparam int WORD_W      = 16;
   localparam int MAX_PROXIES = 32;

   // Callers zero-extend their packed latency vector to the maximum proxy count.
   function automatic logic [LAT_W-1:0] latency_of(
      input logic [LAT_W*MAX_PROXIES-1:0] packed_lat,
      input int                           idx
   );
      return packed_lat[LAT_W*idx +: LAT_W];
   endfunction

endpackage

// File: rtl/bcrypt_serial_capture.sv
// Serial capture path: delays the read strobe by the selected proxy latency
// and shifts the returned bits MSB-first into the packet buffer.
module bcrypt_serial_capture
   import bcrypt_pkg::*;
#(
   parameter int N_BITS = 64,
   parameter int CNT_W  = 7
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic              clear,
   input  logic              strobe,
   input  logic              din,
   input  logic [LAT_W-1:0]  latency,
   output logic [N_BITS-1:0] buffer,
   output logic [CNT_W-1:0]  count,
   output logic              last_capture
);

   localparam int DL = 2**LAT_W;

   logic [DL-1:0] delay_line;
   logic          tap;

   // Tap k of the line is the strobe delayed by k+1 cycles.
   assign tap          = delay_line[latency - 1'b1];
   assign last_capture = tap && (count == CNT_W'(N_BITS-1));

   always_ff @(posedge CLK) begin
      if (reset) begin
         delay_line <= '0;
      end else begin
         delay_line <= {delay_line[DL-2:0], strobe};
      end
   end

   always_ff @(posedge CLK) begin
      if (reset || clear) begin
         buffer <= '0;
         count  <= '0;
      end else if (tap) begin
         buffer <= {buffer[N_BITS-2:0], din};
         count  <= count + 1'b1;
      end
   end

endmodule

// File: rtl/bcrypt_output_collector.sv
// Round-robin collector of serial bcrypt results into 16-bit output FIFO words.
// Optional trailing even-parity bit and sticky err: BCRYPT_OUTPUT_PARITY_EN.
module bcrypt_output_collector
   import bcrypt_pkg::*;
#(
   parameter int                           NUM_PROXIES = 2,
   parameter logic [LAT_W*NUM_PROXIES-1:0] RD_LATENCY  = {4'd5, 4'd3},
   parameter int                           PKT_BITS    = 64,
   parameter int                           EMPTY_GUARD = 8
) (
   input  logic                   CLK,
   input  logic                   reset,
   input  logic [NUM_PROXIES-1:0] empty,
   input  logic [NUM_PROXIES-1:0] dout,
   output logic [NUM_PROXIES-1:0] rd_en,
   output logic [WORD_W-1:0]      out_dout,
   output logic                   out_wr_en,
   input  logic                   out_full,
   output logic                   busy,
   output logic                   err
);

`ifdef BCRYPT_OUTPUT_PARITY_EN
   localparam int N = PKT_BITS + 1;
`else
   localparam int N = PKT_BITS;
`endif
   localparam int WORDS   = PKT_BITS / WORD_W;
   localparam int CNT_MAX = (N > EMPTY_GUARD) ? N : EMPTY_GUARD;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int PTR_W   = (NUM_PROXIES > 1) ? $clog2(NUM_PROXIES) : 1;
   localparam logic [LAT_W*MAX_PROXIES-1:0] LAT_ALL = (LAT_W*MAX_PROXIES)'(RD_LATENCY);

   state_t             state, state_next;
   logic [PTR_W-1:0]   ptr, sel, hit_idx, rd_target;
   logic               hit;
   logic [CNT_W-1:0]   cnt;
   logic [N-1:0]       buffer;
   logic [CNT_W-1:0]   bit_count;
   logic               last_capture;
   logic [PKT_BITS-1:0] packet;

   assign busy      = (state != IDLE);
   assign packet    = buffer[N-1 -: PKT_BITS];
   assign rd_target = (state == IDLE) ? hit_idx : sel;

   bcrypt_serial_capture #(
      .N_BITS (N),
      .CNT_W  (CNT_W)
   ) u_capture (
      .CLK          (CLK),
      .reset        (reset),
      .clear        ((state == IDLE) && hit),
      .strobe       (|rd_en),
      .din          (dout[sel]),
      .latency      (latency_of(LAT_ALL, int'(sel))),
      .buffer       (buffer),
      .count        (bit_count),
      .last_capture (last_capture)
   );

   // First non-empty proxy at or above ptr, wrapping around.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int k = 0; k < NUM_PROXIES; k++) begin
         if (!hit && !empty[(int'(ptr) + k) % NUM_PROXIES]) begin
            hit     = 1'b1;
            hit_idx = PTR_W'((int'(ptr) + k) % NUM_PROXIES);
         end
      end
   end

   always_comb begin
      state_next = state;
      out_wr_en  = 1'b0;
      out_dout   = '0;
      unique case (state)
         IDLE:   if (hit) state_next = READ;
         READ:   if (cnt == CNT_W'(N-1)) state_next = DRAIN;
         DRAIN:  if (last_capture || bit_count == CNT_W'(N)) state_next = UNLOAD;
         UNLOAD: begin
            out_dout  = packet[WORD_W*(WORDS-1-int'(cnt)) +: WORD_W];
            out_wr_en = !out_full;
            if (!out_full && cnt == CNT_W'(WORDS-1)) state_next = GUARD;
         end
         GUARD:  if (cnt == CNT_W'(EMPTY_GUARD-1)) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // cnt restarts on every state change; in UNLOAD it advances only on writes.
   always_ff @(posedge CLK) begin
      if (reset) begin
         state <= IDLE;
         ptr   <= '0;
         sel   <= '0;
         cnt   <= '0;
         rd_en <= '0;
      end else begin
         state <= state_next;
         if (state_next != state) begin
            cnt <= '0;
         end else if (state != UNLOAD || !out_full) begin
            cnt <= cnt + 1'b1;
         end
         if (state == IDLE && hit) begin
            sel <= hit_idx;
         end
         if (state == UNLOAD && state_next == GUARD) begin
            ptr <= (int'(sel) == NUM_PROXIES-1) ? '0 : sel + 1'b1;
         end
         rd_en <= (state_next == READ) ? (NUM_PROXIES'(1) << rd_target) : '0;
      end
   end

`ifdef BCRYPT_OUTPUT_PARITY_EN
   logic parity_bad;

   // Buffer still holds N-1 bits here, so fold in the final incoming bit.
   assign parity_bad = ^{buffer, dout[sel]};

   always_ff @(posedge CLK) begin
      if (reset) begin
         err <= 1'b0;
      end else if (state == DRAIN && last_capture && parity_bad) begin
         err <= 1'b1;
      end
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcrypt_output_collector.sv
// Scoreboard bench for bcrypt_output_collector with a serial proxy model.
// Build with BCRYPT_OUTPUT_PARITY_EN defined to exercise the parity path.
module tb_bcrypt_output_collector;

   localparam int         NP        = 2;
   localparam logic [7:0] LAT       = {4'd5, 4'd3};
   localparam int         PKT       = 64;
   localparam int         GUARD_CYC = 8;
   localparam int         WORDS     = PKT / 16;
`ifdef BCRYPT_OUTPUT_PARITY_EN
   localparam int N = PKT + 1;
`else
   localparam int N = PKT;
`endif

   logic          CLK = 1'b0;
   logic          reset;
   logic [NP-1:0] empty, dout, rd_en;
   logic [15:0]   out_dout;
   logic          out_wr_en, out_full, busy, err;

   bcrypt_output_collector #(
      .NUM_PROXIES (NP),
      .RD_LATENCY  (LAT),
      .PKT_BITS    (PKT),
      .EMPTY_GUARD (GUARD_CYC)
   ) dut (
      .CLK       (CLK),
      .reset     (reset),
      .empty     (empty),
      .dout      (dout),
      .rd_en     (rd_en),
      .out_dout  (out_dout),
      .out_wr_en (out_wr_en),
      .out_full  (out_full),
      .busy      (busy),
      .err       (err)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   // Proxy model: a packet is pending while load_gen != done_gen; each rd_en
   // cycle releases the next bit, which appears on dout LAT cycles later.
   logic [N-1:0] pkt_data [NP];
   int           load_gen [NP];
   int           done_gen [NP];
   int           rcount   [NP];
   logic [14:0]  pipe     [NP];
   logic         model_clr;

   always @(posedge CLK) begin
      for (int i = 0; i < NP; i++) begin
         if (model_clr) begin
            rcount[i]   <= 0;
            done_gen[i] <= load_gen[i];
            pipe[i]     <= '0;
         end else begin
            pipe[i] <= {pipe[i][13:0], (rd_en[i] === 1'b1) ? pkt_data[i][N-1-rcount[i]] : 1'b0};
            if (rd_en[i] === 1'b1) begin
               if (rcount[i] == N-1) begin
                  rcount[i]   <= 0;
                  done_gen[i] <= done_gen[i] + 1;
               end else begin
                  rcount[i] <= rcount[i] + 1;
               end
            end
         end
      end
   end

   for (genvar g = 0; g < NP; g++) begin : g_proxy
      assign dout[g]  = pipe[g][LAT[4*g +: 4] - 4'd1];
      assign empty[g] = (load_gen[g] == done_gen[g]);
   end

   logic [15:0]   exp_q [$];
   int            rd_order [$];
   int            wr_cycles [$];
   int            cyc = 0, wr_count = 0, wr_full_count = 0, multi_rd = 0, busy_cycles = 0;
   int            rd_cycles [NP];
   int            last_rd_end = 0, last_gap = 0;
   logic [NP-1:0] rd_prev = '0;

   task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Monitor samples on the falling edge, away from DUT updates.
   always @(negedge CLK) begin
      cyc++;
      if (busy === 1'b1) busy_cycles++;
      if ($countones(rd_en) > 1) multi_rd++;
      for (int i = 0; i < NP; i++) begin
         if (rd_en[i] === 1'b1) begin
            rd_cycles[i]++;
            if (rd_prev[i] !== 1'b1) begin
               rd_order.push_back(i);
               last_gap = cyc - last_rd_end - 1;
            end
            last_rd_end = cyc;
         end
      end
      rd_prev = rd_en;
      if (out_wr_en === 1'b1) begin
         wr_count++;
         wr_cycles.push_back(cyc);
         if (out_full === 1'b1) wr_full_count++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL unexpected_write observed=%0h expected=none", out_dout);
         end else begin
            check_output("sb_word", {48'd0, out_dout}, {48'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic apply_stimulus(input int proxy, input logic [63:0] payload,
                                 input bit bad_parity, input bit expect_out);
`ifdef BCRYPT_OUTPUT_PARITY_EN
      pkt_data[proxy] = {payload, (^payload) ^ bad_parity};
`else
      pkt_data[proxy] = payload;
      if (bad_parity) $display("[TB] parity flag has no effect in this build");
`endif
      load_gen[proxy]++;
      if (expect_out) begin
         for (int w = 0; w < WORDS; w++) exp_q.push_back(payload[PKT-1-16*w -: 16]);
      end
   endtask

   task automatic wait_packet(input string tag);
      int n = 0;
      bit rose = 1'b0;
      while (busy !== 1'b1 && n < 100) begin step(); n++; end
      if (busy === 1'b1) rose = 1'b1;
      while (busy === 1'b1 && n < 3000) begin step(); n++; end
      check_output({tag, "_started"}, 64'(rose), 64'd1);
      check_output({tag, "_done"}, 64'(busy), 64'd0);
   endtask

   initial begin
      int snap_rd, snap_busy, snap_wr, snap_order, n;
      for (int i = 0; i < NP; i++) load_gen[i] = 0;
      reset     = 1'b1;
      model_clr = 1'b1;
      out_full  = 1'b0;
      repeat (3) step();

      $display("[TB] reset state");
      check_output("rst_rd_en", 64'(rd_en), 64'd0);
      check_output("rst_wr_en", 64'(out_wr_en), 64'd0);
      check_output("rst_dout", 64'(out_dout), 64'd0);
      check_output("rst_busy", 64'(busy), 64'd0);
      check_output("rst_err", 64'(err), 64'd0);
      reset     = 1'b0;
      model_clr = 1'b0;
      step();

      $display("[TB] single packet from proxy 1");
      snap_rd   = rd_cycles[1];
      snap_busy = busy_cycles;
      snap_wr   = wr_count;
      apply_stimulus(1, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b1);
      wait_packet("p1");
      check_output("p1_rd_cycles", 64'(rd_cycles[1] - snap_rd), 64'(N));
      check_output("p1_busy_cycles", 64'(busy_cycles - snap_busy),
                   64'(N + int'(LAT[7:4]) + WORDS + GUARD_CYC));
      check_output("p1_words", 64'(wr_count - snap_wr), 64'd4);
      check_output("p1_consecutive", 64'(wr_cycles[wr_cycles.size()-1] - wr_cycles[wr_cycles.size()-4]), 64'd3);
      check_output("p1_sb_empty", 64'(exp_q.size()), 64'd0);
      check_output("p1_err", 64'(err), 64'd0);

      $display("[TB] both proxies pending");
      snap_order = rd_order.size();
      apply_stimulus(0, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b1);
      apply_stimulus(1, 64'h1111_2222_3333_4444, 1'b0, 1'b1);
      wait_packet("both_a");
      wait_packet("both_b");
      check_output("both_first", 64'(rd_order[snap_order]), 64'd0);
      check_output("both_second", 64'(rd_order[snap_order+1]), 64'd1);
      check_output("both_guard_gap", 64'(last_gap >= GUARD_CYC), 64'd1);
      check_output("both_sb_empty", 64'(exp_q.size()), 64'd0);

      $display("[TB] output FIFO full during unload");
      snap_wr = wr_count;
      apply_stimulus(0, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1'b1);
      n = 0;
      while (wr_count - snap_wr < 2 && n < 500) begin step(); n++; end
      out_full = 1'b1;
      repeat (20) step();
      check_output("full_no_write", 64'(wr_count - snap_wr), 64'd2);
      check_output("full_busy", 64'(busy), 64'd1);
      out_full = 1'b0;
      wait_packet("full");
      check_output("full_words", 64'(wr_count - snap_wr), 64'd4);
      check_output("full_wr_while_full", 64'(wr_full_count), 64'd0);
      check_output("full_sb_empty", 64'(exp_q.size()), 64'd0);

      $display("[TB] reset in the middle of a read");
      snap_rd = rd_cycles[1];
      apply_stimulus(1, 64'hAAAA_5555_0F0F_F0F0, 1'b0, 1'b0);
      n = 0;
      while (rd_cycles[1] - snap_rd < 30 && n < 200) begin step(); n++; end
      reset     = 1'b1;
      model_clr = 1'b1;
      step();
      check_output("abort_rd_en", 64'(rd_en), 64'd0);
      check_output("abort_busy", 64'(busy), 64'd0);
      check_output("abort_err", 64'(err), 64'd0);
      reset     = 1'b0;
      model_clr = 1'b0;
      snap_wr   = wr_count;
      repeat (30) step();
      check_output("abort_no_write", 64'(wr_count - snap_wr), 64'd0);
      apply_stimulus(1, 64'h0F1E_2D3C_4B5A_6978, 1'b0, 1'b1);
      wait_packet("after_abort");
      check_output("after_abort_words", 64'(wr_count - snap_wr), 64'd4);
      check_output("after_abort_sb_empty", 64'(exp_q.size()), 64'd0);

`ifdef BCRYPT_OUTPUT_PARITY_EN
      $display("[TB] parity error handling");
      snap_wr = wr_count;
      apply_stimulus(0, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b1);
      wait_packet("bad_par");
      check_output("bad_par_err", 64'(err), 64'd1);
      check_output("bad_par_words", 64'(wr_count - snap_wr), 64'd4);
      apply_stimulus(1, 64'h0BAD_F00D_1357_2468, 1'b0, 1'b1);
      wait_packet("good_par");
      check_output("good_par_err_sticky", 64'(err), 64'd1);
      check_output("par_sb_empty", 64'(exp_q.size()), 64'd0);
      reset = 1'b1;
      step();
      check_output("par_err_cleared", 64'(err), 64'd0);
      reset = 1'b0;
      step();
`endif

      check_output("one_hot_rd_en", 64'(multi_rd), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
